// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - data-memory port arbiter between core load/store path and debug host.
// Core wins by default; a streak counter bounds how long a waiting debug request can be deferred.
module dmem_port_arbiter #(
  parameter int N          = 64,
  parameter int ADDR_W     = 15,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [N-1:0]      core_wdata,
  input  logic [2:0]        core_width,
  output logic [N-1:0]      core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [N-1:0]      dbg_wdata,
  output logic              dbg_ack,
  output logic [N-1:0]      dbg_rdata,
  output logic              dbg_busy,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-4:0] mem_word_addr,
  output logic [2:0]        mem_byte_off,
  output logic [N-1:0]      mem_wdata,
  output logic [2:0]        mem_width,
  input  logic [N-1:0]      mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_DBG, ST_ACK} state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_STREAK);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_streak;
  logic [3:0]        w_streak_nxt;
  logic [N-1:0]      r_dbg_rdata;
  logic              w_core_req;
  logic              w_grant;
  logic              w_dbg_own;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_core_req   = core_re | core_we;
    w_grant      = (r_state == ST_IDLE) & dbg_req & (~w_core_req | (r_streak == LP_MAX));
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_DBG;
      ST_DBG:  w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // ACK ignores dbg_req for streak purposes; only a dropped request clears it there.
    if (r_state == ST_DBG || !dbg_req) begin
      w_streak_nxt = 4'd0;
    end else if (r_state == ST_IDLE && r_streak != LP_MAX) begin
      w_streak_nxt = r_streak + 4'd1;
    end
  end

  // Reset takes the port back from the debug host immediately, aborting a DBG-cycle write.
  always_comb begin
    w_dbg_own  = (r_state == ST_DBG) & ~reset;
    w_addr     = w_dbg_own ? dbg_addr : core_addr;
    mem_re     = w_dbg_own ? ~dbg_we : core_re;
    mem_we     = w_dbg_own ? dbg_we : core_we;
    mem_wdata  = w_dbg_own ? dbg_wdata : core_wdata;
    mem_width  = w_dbg_own ? 3'b111 : core_width;
    core_stall = w_dbg_own & w_core_req;
    dbg_ack    = (r_state == ST_ACK) & ~reset;
    dbg_busy   = ((r_state == ST_DBG) | (r_state == ST_ACK)) & ~reset;
  end

  assign mem_word_addr = w_addr[ADDR_W-1:3];
  assign mem_byte_off  = w_addr[2:0];
  assign core_rdata    = mem_rdata;
  assign dbg_rdata     = r_dbg_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_streak    <= 4'd0;
      r_dbg_rdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      if (r_state == ST_DBG && !dbg_we) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter.
// A cycle-indexed reference model is compared against every output on each falling edge.
module tb_dmem_port_arbiter;

  localparam int N = 64;
  localparam int AW = 15;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_re, core_we;
  logic [AW-1:0] core_addr;
  logic [N-1:0]  core_wdata;
  logic [2:0]    core_width;
  logic [N-1:0]  core_rdata;
  logic          core_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [N-1:0]  dbg_wdata;
  logic          dbg_ack;
  logic [N-1:0]  dbg_rdata;
  logic          dbg_busy;
  logic          mem_re, mem_we;
  logic [AW-4:0] mem_word_addr;
  logic [2:0]    mem_byte_off;
  logic [N-1:0]  mem_wdata;
  logic [2:0]    mem_width;
  logic [N-1:0]  mem_rdata;

  dmem_port_arbiter #(.N(N), .ADDR_W(AW), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .core_re(core_re), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_width(core_width),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_busy(dbg_busy),
    .mem_re(mem_re), .mem_we(mem_we), .mem_word_addr(mem_word_addr),
    .mem_byte_off(mem_byte_off), .mem_wdata(mem_wdata), .mem_width(mem_width),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: full-word storage, combinational read.
  logic [N-1:0] env_mem [0:4095];
  assign mem_rdata = env_mem[mem_word_addr];
  always @(posedge clk) if (mem_we) env_mem[mem_word_addr] <= mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: a grant at cycle g means service at g+1 and ack at g+2.
  logic [N-1:0] ref_mem [0:4095];
  logic [N-1:0] m_dbg_rdata = '0;
  int           m_grant_cyc = -1;
  int           m_waits     = 0;
  int           cyc         = 0;

  always @(negedge clk) begin
    bit svc, ackp, idle, creq;
    svc  = (m_grant_cyc >= 0) && (cyc == m_grant_cyc + 1);
    ackp = (m_grant_cyc >= 0) && (cyc == m_grant_cyc + 2);
    idle = !svc && !ackp;
    creq = core_re | core_we;
    if (reset) begin
      svc  = 0;
      ackp = 0;
    end
    if (svc) begin
      chk("mem_re", mem_re, !dbg_we);
      chk("mem_we", mem_we, dbg_we);
      chk("mem_word_addr", mem_word_addr, dbg_addr >> 3);
      chk("mem_byte_off", mem_byte_off, dbg_addr % 8);
      chk("mem_wdata", mem_wdata, dbg_wdata);
      chk("mem_width", mem_width, 3'b111);
      chk("core_stall", core_stall, creq);
    end else begin
      chk("mem_re", mem_re, core_re);
      chk("mem_we", mem_we, core_we);
      chk("mem_word_addr", mem_word_addr, core_addr >> 3);
      chk("mem_byte_off", mem_byte_off, core_addr % 8);
      chk("mem_wdata", mem_wdata, core_wdata);
      chk("mem_width", mem_width, core_width);
      chk("core_stall", core_stall, 0);
      if (core_re && !core_we) chk("core_rdata", core_rdata, ref_mem[core_addr >> 3]);
    end
    chk("dbg_ack", dbg_ack, ackp);
    chk("dbg_busy", dbg_busy, svc | ackp);
    chk("dbg_rdata", dbg_rdata, m_dbg_rdata);

    if (svc) begin
      if (dbg_we) ref_mem[dbg_addr >> 3] = dbg_wdata;
    end else if (core_we) begin
      ref_mem[core_addr >> 3] = core_wdata;
    end
    if (reset) begin
      m_grant_cyc = -1;
      m_waits     = 0;
      m_dbg_rdata = '0;
    end else if (svc) begin
      m_waits = 0;
      if (!dbg_we) m_dbg_rdata = ref_mem[dbg_addr >> 3];
    end else if (!dbg_req) begin
      m_waits = 0;
    end else if (idle) begin
      if (!creq || m_waits == MAXS) m_grant_cyc = cyc;
      m_waits = (m_waits + 1 > MAXS) ? MAXS : m_waits + 1;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_re = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_width = 3'b111;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  localparam logic [N-1:0] LIT = 64'hDEAD_BEEF_0000_0001;

  initial begin
    int first_stall, stalls, ack_at;
    logic [5:0] ack_mask;
    bit saw_ack;
    for (int i = 0; i < 4096; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1;
    idle_inputs();
    step(); step();
    reset = 0;

    // Core store then load.
    core_we = 1; core_addr = 15'h0010; core_wdata = LIT;
    sample();
    chk("lit_store_we", mem_we, 1);
    step();
    core_we = 0; core_re = 1;
    sample();
    chk("lit_load_data", core_rdata, LIT);
    chk("lit_load_we", mem_we, 0);
    step();

    // Debug read, core idle: grant c0, DBG c1, ACK c2.
    idle_inputs();
    dbg_req = 1; dbg_addr = 15'h0010;
    sample(); chk("lit_dbg_busy_c0", dbg_busy, 0);
    step();
    sample(); chk("lit_dbg_busy_c1", dbg_busy, 1); chk("lit_dbg_re_c1", mem_re, 1);
    step();
    sample(); chk("lit_dbg_ack_c2", dbg_ack, 1); chk("lit_dbg_rdata", dbg_rdata, LIT);
    step();
    dbg_req = 0;
    sample(); chk("lit_dbg_ack_c3", dbg_ack, 0);
    step();

    // Core busy every cycle; debug write waits MAX_STREAK grants + grant cycle.
    core_re = 1; core_addr = 15'h0100;
    dbg_req = 1; dbg_we = 1; dbg_addr = 15'h0020; dbg_wdata = 64'h55;
    first_stall = -1; stalls = 0; ack_at = -1;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (core_stall) begin
        stalls++;
        if (first_stall < 0) first_stall = i;
      end
      if (dbg_ack) begin
        ack_at = i;
        break;
      end
      step();
    end
    chk("lit_first_stall", first_stall, 5);
    chk("lit_stall_count", stalls, 1);
    chk("lit_ack_cycle", ack_at, 6);
    step();
    dbg_req = 0; dbg_we = 0; core_addr = 15'h0020;
    sample(); chk("lit_load_55", core_rdata, 64'h55);
    step();

    // Held request: acks at c2 and c5 only.
    idle_inputs();
    dbg_req = 1; dbg_addr = 15'h0010;
    ack_mask = '0;
    for (int i = 0; i < 6; i++) begin
      sample();
      ack_mask[i] = dbg_ack;
      step();
    end
    dbg_req = 0;
    chk("lit_ack_mask", ack_mask, 6'b100100);
    step();

    // Reset in DBG aborts the access.
    dbg_req = 1; dbg_addr = 15'h0010;
    step();
    reset = 1;
    sample(); chk("lit_rst_busy", dbg_busy, 0);
    step();
    reset = 0; dbg_req = 0;
    sample();
    chk("lit_rst_ack", dbg_ack, 0);
    chk("lit_rst_rdata", dbg_rdata, 0);
    chk("lit_rst_stall", core_stall, 0);
    step();

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      sample();
      saw_ack = dbg_ack;
      step();
      reset      = ($urandom_range(0, 99) == 0);
      core_re    = ($urandom_range(0, 2) != 0);
      core_we    = ($urandom_range(0, 3) == 0);
      core_addr  = 15'($urandom_range(0, 255));
      core_wdata = {$urandom, $urandom};
      core_width = 3'($urandom_range(0, 7));
      if (saw_ack) begin
        if ($urandom_range(0, 3) != 0) dbg_req = 0;
      end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req   = 1;
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_addr  = 15'($urandom_range(0, 255));
        dbg_wdata = {$urandom, $urandom};
      end
    end
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
